// File: rtl/stream_arbiter.sv
// 2:1 burst-limited round-robin arbiter merging two producer streams into one
// registered downstream stream, with per-channel saturating transfer counters.
module stream_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned BURST  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address_1,
    input  logic [ID_W-1:0]   in_id_1,
    input  logic              in_valid_1,
    output logic              out_stall_1,
    input  logic [ADDR_W-1:0] in_address_2,
    input  logic [ID_W-1:0]   in_id_2,
    input  logic              in_valid_2,
    output logic              out_stall_2,
    input  logic              in_stall,
    output logic [ADDR_W-1:0] out_address,
    output logic [ID_W-1:0]   out_id,
    output logic              out_valid,
    output logic              out_src,
    output logic [CNT_W-1:0]  xfer_cnt_1,
    output logic [CNT_W-1:0]  xfer_cnt_2
);

    localparam int unsigned BurstW = $clog2(BURST + 1);

    typedef enum logic {OwnCh1, OwnCh2} owner_e;

    owner_e              owner_q, owner_d, grant;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [ADDR_W-1:0]   out_address_q, out_address_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic                out_valid_q, out_valid_d;
    logic                out_src_q, out_src_d;
    logic [CNT_W-1:0]    cnt_1_q, cnt_1_d, cnt_2_q, cnt_2_d;
    logic                can_accept, xfer_1, xfer_2, burst_full;

    assign burst_full = (burst_q == BurstW'(BURST));
    assign can_accept = !out_valid_q || !in_stall;

    always_comb begin
        grant = owner_q;
        if (in_valid_1 && !in_valid_2) begin
            grant = OwnCh1;
        end else if (!in_valid_1 && in_valid_2) begin
            grant = OwnCh2;
        end else if (in_valid_1 && in_valid_2 && burst_full) begin
            grant = (owner_q == OwnCh1) ? OwnCh2 : OwnCh1;
        end
    end

    // Reset suppresses transfers so a word presented during reset is not consumed.
    assign xfer_1 = !reset && can_accept && (grant == OwnCh1) && in_valid_1;
    assign xfer_2 = !reset && can_accept && (grant == OwnCh2) && in_valid_2;

    assign out_stall_1 = reset || !(can_accept && (grant == OwnCh1));
    assign out_stall_2 = reset || !(can_accept && (grant == OwnCh2));

    always_comb begin
        owner_d       = owner_q;
        burst_d       = burst_q;
        out_address_d = out_address_q;
        out_id_d      = out_id_q;
        out_valid_d   = out_valid_q;
        out_src_d     = out_src_q;
        cnt_1_d       = cnt_1_q;
        cnt_2_d       = cnt_2_q;

        if (can_accept) begin
            out_valid_d = xfer_1 || xfer_2;
        end

        if (xfer_1) begin
            out_address_d = in_address_1;
            out_id_d      = in_id_1;
            out_src_d     = 1'b0;
            if (cnt_1_q != '1) cnt_1_d = cnt_1_q + 1'b1;
        end else if (xfer_2) begin
            out_address_d = in_address_2;
            out_id_d      = in_id_2;
            out_src_d     = 1'b1;
            if (cnt_2_q != '1) cnt_2_d = cnt_2_q + 1'b1;
        end

        // Ownership and burst length only move on an actual transfer.
        if (xfer_1 || xfer_2) begin
            if (grant == owner_q) begin
                if (!burst_full) burst_d = burst_q + 1'b1;
            end else begin
                owner_d = grant;
                burst_d = BurstW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q       <= OwnCh1;
            burst_q       <= '0;
            out_address_q <= '0;
            out_id_q      <= '0;
            out_valid_q   <= 1'b0;
            out_src_q     <= 1'b0;
            cnt_1_q       <= '0;
            cnt_2_q       <= '0;
        end else begin
            owner_q       <= owner_d;
            burst_q       <= burst_d;
            out_address_q <= out_address_d;
            out_id_q      <= out_id_d;
            out_valid_q   <= out_valid_d;
            out_src_q     <= out_src_d;
            cnt_1_q       <= cnt_1_d;
            cnt_2_q       <= cnt_2_d;
        end
    end

    assign out_address = out_address_q;
    assign out_id      = out_id_q;
    assign out_valid   = out_valid_q;
    assign out_src     = out_src_q;
    assign xfer_cnt_1  = cnt_1_q;
    assign xfer_cnt_2  = cnt_2_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Randomized bench for stream_arbiter against a cycle-level behavioural model
// of the grant, output register and counter rules.
module tb_stream_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned BURST  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] in_address_1, in_address_2, out_address;
    logic [ID_W-1:0]   in_id_1, in_id_2, out_id;
    logic              in_valid_1, in_valid_2, in_stall;
    logic              out_stall_1, out_stall_2, out_valid, out_src;
    logic [CNT_W-1:0]  xfer_cnt_1, xfer_cnt_2;

    stream_arbiter #(
        .ADDR_W(ADDR_W),
        .ID_W  (ID_W),
        .BURST (BURST),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_address_1(in_address_1),
        .in_id_1     (in_id_1),
        .in_valid_1  (in_valid_1),
        .out_stall_1 (out_stall_1),
        .in_address_2(in_address_2),
        .in_id_2     (in_id_2),
        .in_valid_2  (in_valid_2),
        .out_stall_2 (out_stall_2),
        .in_stall    (in_stall),
        .out_address (out_address),
        .out_id      (out_id),
        .out_valid   (out_valid),
        .out_src     (out_src),
        .xfer_cnt_1  (xfer_cnt_1),
        .xfer_cnt_2  (xfer_cnt_2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int                m_owner;
    int                m_burst;
    int                m_cnt1, m_cnt2;
    logic              m_valid, m_src;
    logic [ADDR_W-1:0] m_addr;
    logic [ID_W-1:0]   m_id;

    // Producer state for the random phase
    logic              p_v1, p_v2;
    logic [ADDR_W-1:0] p_a1, p_a2;
    logic [ID_W-1:0]   p_i1, p_i2;
    logic              s1, s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 1; m_burst = 0; m_cnt1 = 0; m_cnt2 = 0;
        m_valid = 1'b0; m_src = 1'b0; m_addr = '0; m_id = '0;
    endtask

    // One clock cycle: drive inputs, check stalls, advance model across the edge, check outputs.
    task automatic cycle(input logic rst, input logic v1, input logic v2, input logic st,
                         input logic [ADDR_W-1:0] a1, input logic [ID_W-1:0] i1,
                         input logic [ADDR_W-1:0] a2, input logic [ID_W-1:0] i2,
                         output logic es1, output logic es2);
        int  g;
        bit  ca;
        reset = rst; in_valid_1 = v1; in_valid_2 = v2; in_stall = st;
        in_address_1 = a1; in_id_1 = i1; in_address_2 = a2; in_id_2 = i2;
        #1;
        if (v1 && !v2)                        g = 1;
        else if (v2 && !v1)                   g = 2;
        else if (v1 && v2 && m_burst == BURST) g = 3 - m_owner;
        else                                  g = m_owner;
        ca  = !m_valid || !st;
        es1 = rst || !(ca && g == 1);
        es2 = rst || !(ca && g == 2);
        check("stall_1", 32'(out_stall_1), 32'(es1));
        check("stall_2", 32'(out_stall_2), 32'(es2));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ca) begin
            if ((g == 1 && v1) || (g == 2 && v2)) begin
                m_valid = 1'b1;
                m_src   = (g == 2);
                m_addr  = (g == 1) ? a1 : a2;
                m_id    = (g == 1) ? i1 : i2;
                if (g == 1) m_cnt1 = (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
                else        m_cnt2 = (m_cnt2 < CMAX) ? m_cnt2 + 1 : CMAX;
                if (g == m_owner) m_burst = (m_burst < BURST) ? m_burst + 1 : BURST;
                else begin m_owner = g; m_burst = 1; end
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_address", 32'(out_address), 32'(m_addr));
            check("out_id", 32'(out_id), 32'(m_id));
            check("out_src", 32'(out_src), 32'(m_src));
        end
        check("xfer_cnt_1", 32'(xfer_cnt_1), 32'(m_cnt1));
        check("xfer_cnt_2", 32'(xfer_cnt_2), 32'(m_cnt2));
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [ID_W-1:0]   d;
        logic              exp_src [9];
        model_reset();
        reset = 1'b1; in_valid_1 = 1'b0; in_valid_2 = 1'b0; in_stall = 1'b0;
        in_address_1 = '0; in_address_2 = '0; in_id_1 = '0; in_id_2 = '0;
        @(posedge clk); #1;

        // Reset held two cycles with both producers valid
        for (int k = 0; k < 2; k++) cycle(1, 1, 1, 0, 16'h1111, 8'h11, 16'h2222, 8'h22, s1, s2);
        check("reset_valid", 32'(out_valid), 32'd0);

        // Only ch1 valid for six cycles
        for (int k = 0; k < 6; k++)
            cycle(0, 1, 0, 0, ADDR_W'(16'h0100 + k), ID_W'(k), 16'h0, 8'h0, s1, s2);
        check("ch1_only_cnt", 32'(xfer_cnt_1), 32'd6);
        cycle(1, 0, 0, 0, '0, '0, '0, '0, s1, s2);

        // Both valid: src pattern 1,1,1,1,2,2,2,2,1 one cycle later
        exp_src = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int k = 0; k < 9; k++) begin
            cycle(0, 1, 1, 0, ADDR_W'(16'h1000 + k), 8'hA1, ADDR_W'(16'h2000 + k), 8'hB2, s1, s2);
            check("rr_pattern", 32'(out_src), 32'(exp_src[k]));
            check("one_unstalled", 32'(out_stall_1 | out_stall_2), 32'd1);
        end

        // Downstream stall for three cycles, then release
        for (int k = 0; k < 3; k++)
            cycle(0, 1, 1, 1, 16'h3000, 8'hC3, 16'h4000, 8'hD4, s1, s2);
        check("frozen_addr", 32'(out_address), 32'h1008);
        cycle(0, 1, 1, 0, 16'h3000, 8'hC3, 16'h4000, 8'hD4, s1, s2);
        check("release_addr", 32'(out_address), 32'h3000);

        // Mid-burst reset: after three ch2 transfers, reset then both valid -> ch1 first
        cycle(1, 0, 0, 0, '0, '0, '0, '0, s1, s2);
        for (int k = 0; k < 3; k++)
            cycle(0, 0, 1, 0, '0, '0, ADDR_W'(16'h5000 + k), 8'h55, s1, s2);
        cycle(1, 1, 1, 0, 16'h6000, 8'h66, 16'h7000, 8'h77, s1, s2);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        cycle(0, 1, 1, 0, 16'h6000, 8'h66, 16'h7000, 8'h77, s1, s2);
        check("post_reset_src", 32'(out_src), 32'd0);

        // Twenty ch2 transfers saturate the 4-bit counter
        cycle(1, 0, 0, 0, '0, '0, '0, '0, s1, s2);
        for (int k = 0; k < 20; k++)
            cycle(0, 0, 1, 0, '0, '0, ADDR_W'(k), 8'h99, s1, s2);
        check("sat_cnt_2", 32'(xfer_cnt_2), 32'd15);

        // Random producers that hold their word while stalled
        cycle(1, 0, 0, 0, '0, '0, '0, '0, s1, s2);
        p_v1 = 0; p_v2 = 0; p_a1 = '0; p_a2 = '0; p_i1 = '0; p_i2 = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!p_v1 || !s1) begin
                p_v1 = ($urandom_range(0, 3) != 0);
                a = ADDR_W'($urandom); d = ID_W'($urandom);
                p_a1 = a; p_i1 = d;
            end
            if (!p_v2 || !s2) begin
                p_v2 = ($urandom_range(0, 3) != 0);
                a = ADDR_W'($urandom); d = ID_W'($urandom);
                p_a2 = a; p_i2 = d;
            end
            cycle(($urandom_range(0, 99) == 0), p_v1, p_v2, ($urandom_range(0, 2) == 0),
                  p_a1, p_i1, p_a2, p_i2, s1, s2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
